// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller and its datapath/memories.
// The slave modport is the controller side; the master modport is the datapath side.
interface multicycle_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  logic [6:0]           opcode;
  logic                 imem_ready;
  logic                 dmem_ready;
  logic                 branch_taken;
  logic                 imem_req;
  logic                 ir_write;
  logic                 pc_write;
  logic [1:0]           pc_src;
  logic                 dmem_read;
  logic                 dmem_write;
  logic                 regwrite;
  logic [1:0]           wb_sel;
  logic [2:0]           state;
  logic                 illegal;
  logic [CNT_WIDTH-1:0] instret;

  modport slave (
    input  opcode, imem_ready, dmem_ready, branch_taken,
    output imem_req, ir_write, pc_write, pc_src, dmem_read, dmem_write,
           regwrite, wb_sel, state, illegal, instret
  );

  modport master (
    output opcode, imem_ready, dmem_ready, branch_taken,
    input  imem_req, ir_write, pc_write, pc_src, dmem_read, dmem_write,
           regwrite, wb_sel, state, illegal, instret
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I-style control FSM: FETCH/DECODE/EXEC/MEM/WB with an illegal-opcode
// trap and a retired-instruction counter.
module multicycle_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  multicycle_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_TARGET = 2'b01;
  localparam logic [1:0] PC_ALU    = 2'b10;

  localparam logic [1:0] WB_ALU    = 2'b00;
  localparam logic [1:0] WB_MEM    = 2'b01;
  localparam logic [1:0] WB_LINK   = 2'b10;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [6:0]           op_q;
  logic [CNT_WIDTH-1:0] instret_q;
  logic                 retire;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_OP, OP_IMM, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal = 1'b1;
      default:                           is_legal = 1'b0;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FETCH;
      op_q      <= 7'b0000000;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) op_q <= bus.opcode;
      if (retire) instret_q <= instret_q + CNT_ONE;
    end
  end

  // NOTE: every output and next-state value gets a default before the case so that
  // no path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d        = state_q;
    retire         = 1'b0;
    bus.imem_req   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = PC_PLUS4;
    bus.dmem_read  = 1'b0;
    bus.dmem_write = 1'b0;
    bus.regwrite   = 1'b0;
    bus.wb_sel     = WB_ALU;
    bus.illegal    = 1'b0;

    case (state_q)
      FETCH: begin
        // Fetch is held off while reset is asserted; it comes up as soon as rst releases.
        bus.imem_req = rst;
        bus.ir_write = rst & bus.imem_ready;
        if (bus.imem_ready) state_d = DECODE;
      end
      DECODE: begin
        state_d = is_legal(bus.opcode) ? EXEC : TRAP;
      end
      EXEC: begin
        case (op_q)
          OP_BRANCH: begin
            bus.pc_write = 1'b1;
            bus.pc_src   = bus.branch_taken ? PC_TARGET : PC_PLUS4;
            retire       = 1'b1;
            state_d      = FETCH;
          end
          OP_LOAD, OP_STORE: state_d = MEM;
          default:           state_d = WB;
        endcase
      end
      MEM: begin
        bus.dmem_read  = (op_q == OP_LOAD);
        bus.dmem_write = (op_q != OP_LOAD);
        if (bus.dmem_ready) begin
          if (op_q == OP_LOAD) begin
            state_d = WB;
          end else begin
            bus.pc_write = 1'b1;
            retire       = 1'b1;
            state_d      = FETCH;
          end
        end
      end
      WB: begin
        bus.regwrite = 1'b1;
        bus.pc_write = 1'b1;
        retire       = 1'b1;
        state_d      = FETCH;
        if (op_q == OP_LOAD) bus.wb_sel = WB_MEM;
        else if (op_q == OP_JAL || op_q == OP_JALR) bus.wb_sel = WB_LINK;
        if (op_q == OP_JAL) bus.pc_src = PC_TARGET;
        else if (op_q == OP_JALR) bus.pc_src = PC_ALU;
      end
      TRAP: begin
        bus.illegal = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  assign bus.state   = state_q;
  assign bus.instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (4-bit counter so wrap is reachable).
module tb_multicycle_ctrl;

  localparam int W = 4;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] OPR    = 7'b0110011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  multicycle_ctrl_if #(.CNT_WIDTH(W)) bus ();

  multicycle_ctrl #(.CNT_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge, then settle for sampling.
  task automatic cyc(input logic [6:0] op, input logic ir, input logic dr, input logic bt);
    @(negedge clk);
    bus.opcode       = op;
    bus.imem_ready   = ir;
    bus.dmem_ready   = dr;
    bus.branch_taken = bt;
    #1;
  endtask

  task automatic do_branch();
    cyc(BRANCH, 1'b1, 1'b0, 1'b1);
    cyc(BRANCH, 1'b0, 1'b0, 1'b1);
    cyc(BRANCH, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    bus.opcode = '0; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; bus.branch_taken = 1'b0;

    #2;
    check("rst_state",    bus.state, 0);
    check("rst_instret",  bus.instret, 0);
    check("rst_imem_req", bus.imem_req, 0);
    check("rst_illegal",  bus.illegal, 0);
    @(negedge clk); rst = 1'b1; #1;
    check("post_rst_imem_req", bus.imem_req, 1);

    // OP-IMM; opcode changes after DECODE to prove EXEC/WB use the latched copy
    cyc(OPIMM, 1'b0, 1'b0, 1'b0);
    check("fetch_wait_state", bus.state, 0);
    check("fetch_wait_irw",   bus.ir_write, 0);
    cyc(OPIMM, 1'b1, 1'b0, 1'b0);
    check("opimm_fetch_irw", bus.ir_write, 1);
    cyc(OPIMM, 1'b0, 1'b0, 1'b0);
    check("opimm_decode", bus.state, 1);
    cyc(LOAD, 1'b0, 1'b1, 1'b0);
    check("opimm_exec", bus.state, 2);
    check("opimm_exec_pcw", bus.pc_write, 0);
    cyc(LOAD, 1'b0, 1'b1, 1'b0);
    check("opimm_wb", bus.state, 4);
    check("opimm_wb_rw", bus.regwrite, 1);
    check("opimm_wb_sel", bus.wb_sel, 0);
    check("opimm_wb_pcw", bus.pc_write, 1);
    check("opimm_wb_pcsrc", bus.pc_src, 0);
    cyc(7'b0, 1'b0, 1'b0, 1'b0);
    check("opimm_done", bus.state, 0);
    check("opimm_instret", bus.instret, 1);

    // LOAD with two memory wait cycles: 7 cycles total
    cyc(LOAD, 1'b1, 1'b0, 1'b0);
    cyc(LOAD, 1'b0, 1'b0, 1'b0);
    cyc(LOAD, 1'b0, 1'b0, 1'b0);
    check("load_exec", bus.state, 2);
    cyc(LOAD, 1'b0, 1'b0, 1'b0);
    check("load_mem1_state", bus.state, 3);
    check("load_mem1_rd", bus.dmem_read, 1);
    cyc(LOAD, 1'b0, 1'b0, 1'b0);
    check("load_mem2_rd", bus.dmem_read, 1);
    cyc(LOAD, 1'b0, 1'b1, 1'b0);
    check("load_mem3_rd", bus.dmem_read, 1);
    check("load_mem3_wr", bus.dmem_write, 0);
    check("load_mem3_state", bus.state, 3);
    cyc(LOAD, 1'b0, 1'b0, 1'b0);
    check("load_wb_state", bus.state, 4);
    check("load_wb_sel", bus.wb_sel, 1);
    check("load_wb_rw", bus.regwrite, 1);
    cyc(7'b0, 1'b0, 1'b0, 1'b0);
    check("load_done", bus.state, 0);
    check("load_instret", bus.instret, 2);

    // BRANCH taken, then not taken: 3 cycles each
    cyc(BRANCH, 1'b1, 1'b0, 1'b1);
    cyc(BRANCH, 1'b0, 1'b0, 1'b1);
    cyc(BRANCH, 1'b0, 1'b0, 1'b1);
    check("brt_exec", bus.state, 2);
    check("brt_pcw", bus.pc_write, 1);
    check("brt_pcsrc", bus.pc_src, 1);
    check("brt_rw", bus.regwrite, 0);
    cyc(7'b0, 1'b0, 1'b0, 1'b0);
    check("brt_done", bus.state, 0);
    check("brt_instret", bus.instret, 3);
    cyc(BRANCH, 1'b1, 1'b0, 1'b0);
    cyc(BRANCH, 1'b0, 1'b0, 1'b0);
    cyc(BRANCH, 1'b0, 1'b0, 1'b0);
    check("brn_pcw", bus.pc_write, 1);
    check("brn_pcsrc", bus.pc_src, 0);
    cyc(7'b0, 1'b0, 1'b0, 1'b0);
    check("brn_instret", bus.instret, 4);

    // JALR and JAL
    cyc(JALR, 1'b1, 1'b0, 1'b0);
    cyc(JALR, 1'b0, 1'b0, 1'b0);
    cyc(JALR, 1'b0, 1'b0, 1'b0);
    cyc(JALR, 1'b0, 1'b0, 1'b0);
    check("jalr_wb", bus.state, 4);
    check("jalr_wb_sel", bus.wb_sel, 2);
    check("jalr_pcsrc", bus.pc_src, 2);
    cyc(JAL, 1'b1, 1'b0, 1'b0);
    check("jalr_instret", bus.instret, 5);
    cyc(JAL, 1'b0, 1'b0, 1'b0);
    cyc(JAL, 1'b0, 1'b0, 1'b0);
    cyc(JAL, 1'b0, 1'b0, 1'b0);
    check("jal_wb", bus.state, 4);
    check("jal_wb_sel", bus.wb_sel, 2);
    check("jal_pcsrc", bus.pc_src, 1);

    // STORE with zero-wait memory: 4 cycles
    cyc(STORE, 1'b1, 1'b0, 1'b0);
    check("jal_instret", bus.instret, 6);
    cyc(STORE, 1'b0, 1'b0, 1'b0);
    cyc(STORE, 1'b0, 1'b0, 1'b0);
    cyc(STORE, 1'b0, 1'b1, 1'b0);
    check("store_mem", bus.state, 3);
    check("store_wr", bus.dmem_write, 1);
    check("store_rd", bus.dmem_read, 0);
    check("store_pcw", bus.pc_write, 1);
    check("store_pcsrc", bus.pc_src, 0);
    check("store_rw", bus.regwrite, 0);
    cyc(7'b0, 1'b0, 1'b0, 1'b0);
    check("store_done", bus.state, 0);
    check("store_instret", bus.instret, 7);

    // Asynchronous reset mid-EXEC
    cyc(OPR, 1'b1, 1'b0, 1'b0);
    cyc(OPR, 1'b0, 1'b0, 1'b0);
    cyc(OPR, 1'b0, 1'b0, 1'b0);
    check("arst_pre_exec", bus.state, 2);
    rst = 1'b0; #1;
    check("arst_state", bus.state, 0);
    check("arst_instret", bus.instret, 0);
    check("arst_rw", bus.regwrite, 0);
    check("arst_pcw", bus.pc_write, 0);
    check("arst_rd", bus.dmem_read, 0);
    check("arst_wr", bus.dmem_write, 0);
    check("arst_imem_req", bus.imem_req, 0);
    #2 rst = 1'b1;

    // Illegal opcode traps and holds until reset
    cyc(7'b0, 1'b1, 1'b0, 1'b0);
    check("ill_fetch", bus.state, 0);
    cyc(7'b0, 1'b0, 1'b0, 1'b0);
    check("ill_decode", bus.state, 1);
    cyc(7'b0, 1'b1, 1'b1, 1'b1);
    check("ill_trap", bus.state, 7);
    check("ill_flag", bus.illegal, 1);
    check("ill_imem_req", bus.imem_req, 0);
    for (int i = 0; i < 22; i++) cyc(OPIMM, 1'b1, 1'b1, 1'b1);
    check("ill_hold_state", bus.state, 7);
    check("ill_hold_flag", bus.illegal, 1);
    check("ill_hold_irw", bus.ir_write, 0);
    check("ill_hold_pcw", bus.pc_write, 0);
    check("ill_instret", bus.instret, 0);
    rst = 1'b0; #1;
    check("ill_rst_state", bus.state, 0);
    check("ill_rst_flag", bus.illegal, 0);
    #2 rst = 1'b1;

    // Counter wrap: 15 retirements reach 4'hF, the 16th wraps to 0
    for (int i = 0; i < 15; i++) do_branch();
    cyc(7'b0, 1'b0, 1'b0, 1'b0);
    check("wrap_15", bus.instret, 15);
    do_branch();
    cyc(7'b0, 1'b0, 1'b0, 1'b0);
    check("wrap_0", bus.instret, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one parameter: CNT_WIDTH, default 32, width of the retired-instruction counter.
REQ-002 The block SHALL have these ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- opcode  input  7  instruction[6:0] from the instruction register
- imem_ready  input  1  instruction memory has delivered the word
- dmem_ready  input  1  data memory access complete
- branch_taken  input  1  branch compare result from the execute stage
- imem_req  output  1  instruction fetch request
- ir_write  output  1  load the instruction register
- pc_write  output  1  update the PC
- pc_src  output  2  PC source: 00 = pc+4, 01 = branch/jal target, 10 = ALU result (jalr)
- dmem_read  output  1  data memory read
- dmem_write  output  1  data memory write
- regwrite  output  1  register file write enable
- wb_sel  output  2  writeback source: 00 = ALU, 01 = memory, 10 = pc+4
- state  output  3  current FSM state
- illegal  output  1  illegal opcode trap
- instret  output  CNT_WIDTH  retired-instruction count

Function
REQ-003 The FSM SHALL use these state encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7; encodings 5 and 6 SHALL go to FETCH on the next clock.
REQ-004 Legal opcodes SHALL be: LOAD 0000011, STORE 0100011, OP 0110011, OP-IMM 0010011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
REQ-005 The block SHALL latch opcode into an internal register on the DECODE clock edge; EXEC, MEM and WB decisions SHALL use only the latched value.
REQ-006 In FETCH, imem_req SHALL be 1; ir_write SHALL equal imem_ready (Mealy); imem_ready=1 SHALL move the FSM to DECODE, otherwise it SHALL stay in FETCH.
REQ-007 DECODE SHALL last exactly one cycle: an illegal opcode SHALL go to TRAP, any legal opcode SHALL go to EXEC.
REQ-008 EXEC SHALL last exactly one cycle with these transitions:
- BRANCH: pc_write=1, pc_src = branch_taken ? 01 : 00, instret increments, next state FETCH.
- LOAD or STORE: next state MEM.
- All other legal opcodes: next state WB.
REQ-009 In MEM:
- dmem_read=1 for LOAD, or dmem_write=1 for STORE, held until dmem_ready=1.
- On dmem_ready, STORE SHALL assert pc_write=1 with pc_src=00, increment instret and go to FETCH.
- On dmem_ready, LOAD SHALL go to WB.
REQ-010 WB SHALL last one cycle and assert regwrite=1 and pc_write=1, increment instret and go to FETCH, with:
- wb_sel = 01 for LOAD, 10 for JAL/JALR, 00 otherwise.
- pc_src = 01 for JAL, 10 for JALR, 00 otherwise.
REQ-011 In TRAP, illegal SHALL be 1, every enable output SHALL be 0, and the FSM SHALL stay in TRAP until reset.
REQ-012 Enable outputs (imem_req, ir_write, pc_write, dmem_read, dmem_write, regwrite) SHALL be 0 in every state and condition not listed above; pc_src and wb_sel SHALL be 00 when not specified.
REQ-013 imem_ready SHALL be ignored outside FETCH, and dmem_ready SHALL be ignored outside MEM.
REQ-014 instret SHALL increment by exactly 1 per retired instruction and wrap from 2^CNT_WIDTH-1 to 0; illegal instructions SHALL NOT be counted.
REQ-015 With zero-wait memories, instruction latency SHALL be: BRANCH 3 cycles; STORE and OP/OP-IMM/LUI/AUIPC/JAL/JALR 4 cycles; LOAD 5 cycles. Each wait cycle adds one cycle.

Reset
REQ-016 On rst=0, asynchronously and regardless of clk:
- state SHALL become FETCH.
- instret SHALL become 0.
- illegal and all enables SHALL become 0, except imem_req, which SHALL be 1 once rst deasserts.
- The latched opcode SHALL become 0000000.
REQ-017 Reset asserted mid-operation (including MEM with a pending access, or TRAP) SHALL abort the instruction without retiring it, and operation SHALL resume at FETCH after rst returns to 1.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Reset: rst=0 mid-EXEC -> state=0, instret=0, regwrite=pc_write=dmem_read=dmem_write=0 immediately, without waiting for a clock edge.
- OP-IMM 0010011, imem_ready=1 -> states 0,1,2,4,0; WB cycle has regwrite=1, wb_sel=00, pc_write=1, pc_src=00; instret=1.
- LOAD 0000011 with dmem_ready low for 2 cycles -> dmem_read=1 for 3 cycles, WB wb_sel=01, 7 cycles total.
- BRANCH with branch_taken=1 -> EXEC cycle has pc_write=1, pc_src=01; regwrite never 1; 3 cycles; repeat with branch_taken=0 -> pc_src=00.
- JALR 1100111 -> WB wb_sel=10, pc_src=10; JAL 1101111 -> wb_sel=10, pc_src=01.
- Opcode 0000000 -> TRAP (state=7), illegal=1, instret unchanged, stays 20+ cycles; rst pulse -> FETCH, illegal=0.
- instret preloaded near the wrap point (CNT_WIDTH=4, 15 retirements) -> 16th retirement gives instret=0.
